// File: rtl/clock_monitor.sv
// clock_monitor: measures period and high time of an async clock in clk cycles.
// Define CLOCK_MONITOR_CHECK_EN to add tolerance checks against expected values.
module clock_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             start,
  input  logic             cont,
`ifdef CLOCK_MONITOR_CHECK_EN
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] tol,
  output logic             period_err,
  output logic             duty_err,
`endif
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             valid,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_e;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  // last value a counter may hold before the next step would saturate
  localparam logic [CNT_W-1:0] LAST = ~ONE;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_s;
  logic                   rise;
  logic                   fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise   = sync_s & ~hist_q;
  assign fall   = ~sync_s & hist_q;

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    hi_d      = hi_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          per_d   = '0;
          hi_d    = '0;
        end
      end
      ARM: begin
        if (rise) begin
          state_d = HIGH;
          per_d   = ONE;
          hi_d    = ONE;
        end else if (per_q == LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          per_d = per_q + ONE;
        end
      end
      HIGH: begin
        if (per_q == LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          per_d = per_q + ONE;
          if (fall) state_d = LOW;
          else hi_d = hi_q + ONE;
        end
      end
      LOW: begin
        if (rise) begin
          period_d = per_q;
          high_d   = hi_q;
          valid_d  = 1'b1;
          // the closing rise doubles as the opening rise of the next period
          if (cont) begin
            state_d = HIGH;
            per_d   = ONE;
            hi_d    = ONE;
          end else begin
            state_d = IDLE;
          end
        end else if (per_q == LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          per_d = per_q + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= IDLE;
      per_q     <= '0;
      hi_q      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], clk_in};
      hist_q    <= sync_s;
      state_q   <= state_d;
      per_q     <= per_d;
      hi_q      <= hi_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign meas_period = period_q;
  assign meas_high   = high_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign busy        = (state_q != IDLE);

`ifdef CLOCK_MONITOR_CHECK_EN
  logic [CNT_W-1:0] per_dev;
  logic [CNT_W-1:0] hi_dev;
  logic             perr_q;
  logic             derr_q;

  assign per_dev = (per_q > exp_period) ? per_q - exp_period
                                        : exp_period - per_q;
  assign hi_dev  = (hi_q > exp_high) ? hi_q - exp_high
                                     : exp_high - hi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
      derr_q <= 1'b0;
    end else if (valid_d) begin
      perr_q <= (per_dev > tol);
      derr_q <= (hi_dev > tol);
    end
  end

  assign period_err = perr_q;
  assign duty_err   = derr_q;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: timestamp model of clock_monitor checked every cycle,
// plus directed scenarios with literal expectations.
module tb_clock_monitor;

  localparam int CW     = 8;
  localparam int SS     = 2;
  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_MEAS = 2;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic clk_in = 1'b0;
  logic start  = 1'b0;
  logic cont   = 1'b0;
  logic [CW-1:0] meas_period;
  logic [CW-1:0] meas_high;
  logic valid;
  logic busy;
  logic timeout;
`ifdef CLOCK_MONITOR_CHECK_EN
  logic [CW-1:0] exp_period = 8'd8;
  logic [CW-1:0] exp_high   = 8'd3;
  logic [CW-1:0] tol        = 8'd0;
  logic period_err;
  logic duty_err;
`endif

  clock_monitor #(.CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_in     (clk_in),
    .start      (start),
    .cont       (cont),
`ifdef CLOCK_MONITOR_CHECK_EN
    .exp_period (exp_period),
    .exp_high   (exp_high),
    .tol        (tol),
    .period_err (period_err),
    .duty_err   (duty_err),
`endif
    .meas_period(meas_period),
    .meas_high  (meas_high),
    .valid      (valid),
    .busy       (busy),
    .timeout    (timeout)
  );

  int checks   = 0;
  int failures = 0;

  // clk_in: mode 0 = low, 1 = running, 2 = stuck high
  int ck_mode = 0;
  int ck_per  = 80;
  int ck_high = 30;

  always #5 clk = ~clk;

  initial begin
    #8;
    forever begin
      if (ck_mode == 1) begin
        clk_in = 1'b1;
        #(ck_high);
        clk_in = 1'b0;
        #(ck_per - ck_high);
      end else begin
        clk_in = (ck_mode == 2);
        #10;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle time %0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // model: clk_in samples at each edge, results from rise/fall timestamps
  int cyc      = 0;
  int smp[$];
  int m_mode   = M_IDLE;
  int t_arm    = 0;
  int t_rise   = 0;
  int t_fall   = -1;
  int m_period = 0;
  int m_high   = 0;
  bit m_valid  = 1'b0;
  bit m_to     = 1'b0;
  bit chk_on   = 1'b0;
`ifdef CLOCK_MONITOR_CHECK_EN
  bit m_perr   = 1'b0;
  bit m_derr   = 1'b0;
`endif

  task automatic model_step();
    bit r;
    bit f;
    cyc++;
    r = (smp[SS-1] != 0) && (smp[SS] == 0);
    f = (smp[SS-1] == 0) && (smp[SS] != 0);
    m_valid = 1'b0;
    m_to    = 1'b0;
    if (rst) begin
      m_mode   = M_IDLE;
      m_period = 0;
      m_high   = 0;
`ifdef CLOCK_MONITOR_CHECK_EN
      m_perr = 1'b0;
      m_derr = 1'b0;
`endif
      foreach (smp[i]) smp[i] = 0;
      smp.push_front(0);
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (start) begin
            m_mode = M_ARM;
            t_arm  = cyc;
          end
        end
        M_ARM: begin
          if (r) begin
            m_mode = M_MEAS;
            t_rise = cyc;
            t_fall = -1;
          end else if (cyc - t_arm >= 255) begin
            m_to   = 1'b1;
            m_mode = M_IDLE;
          end
        end
        default: begin
          if (r && t_fall >= 0) begin
            m_period = cyc - t_rise;
            m_high   = t_fall - t_rise;
            m_valid  = 1'b1;
`ifdef CLOCK_MONITOR_CHECK_EN
            m_perr = absd(m_period, int'(exp_period)) > int'(tol);
            m_derr = absd(m_high, int'(exp_high)) > int'(tol);
`endif
            if (cont) begin
              t_rise = cyc;
              t_fall = -1;
            end else begin
              m_mode = M_IDLE;
            end
          end else if (cyc - t_rise >= 254) begin
            m_to   = 1'b1;
            m_mode = M_IDLE;
          end else if (f && t_fall < 0) begin
            t_fall = cyc;
          end
        end
      endcase
      smp.push_front(int'(clk_in));
    end
    while (smp.size() > 8) void'(smp.pop_back());
  endtask

  initial begin
    for (int i = 0; i < 8; i++) smp.push_front(0);
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("valid", int'(valid), int'(m_valid));
        chk("timeout", int'(timeout), int'(m_to));
        chk("busy", int'(busy), int'(m_mode != M_IDLE));
        chk("meas_period", int'(meas_period), m_period);
        chk("meas_high", int'(meas_high), m_high);
`ifdef CLOCK_MONITOR_CHECK_EN
        chk("period_err", int'(period_err), int'(m_perr));
        chk("duty_err", int'(duty_err), int'(m_derr));
`endif
      end
    end
  end

  // which: 0 valid, 1 timeout, 2 model in high phase
  task automatic wait_for(input string nm, input int which, input int lim,
                          output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < lim && !hit; i++) begin
      @(negedge clk);
      unique case (which)
        0: hit = (valid == 1'b1);
        1: hit = (timeout == 1'b1);
        default: hit = (m_mode == M_MEAS) && (t_fall < 0);
      endcase
      if (hit) at = cyc;
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL wait_%s: got no event expected one within %0d cycles", nm, lim);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int at;
  int prev;
  int t0;

  initial begin
    // reset held with start high: reset wins
    @(posedge clk);
    #2 rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #2 chk_on = 1'b1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_period", int'(meas_period), 0);
    chk("rst_high", int'(meas_high), 0);
    idle(2);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);

    // single measurement, 80/30 ns
    ck_mode = 1;
    idle(20);
    pulse_start();
    wait_for("single", 0, 40, at);
    chk("single_period", int'(meas_period), 8);
    chk("single_high", int'(meas_high), 3);
    chk("single_busy", int'(busy), 0);
    chk("model_period", m_period, 8);
    chk("model_high", m_high, 3);

    // continuous mode, back-to-back results
    cont = 1'b1;
    pulse_start();
    wait_for("cont_first", 0, 40, prev);
    for (int k = 0; k < 4; k++) begin
      wait_for("cont_next", 0, 12, at);
      chk("cont_gap", at - prev, 8);
      chk("cont_period", int'(meas_period), 8);
      chk("cont_high", int'(meas_high), 3);
      prev = at;
    end
    cont = 1'b0;
    wait_for("cont_last", 0, 12, at);
    chk("cont_last_gap", at - prev, 8);
    chk("cont_stop_busy", int'(busy), 0);

    // start while busy is ignored
    pulse_start();
    idle(5);
    #0 chk("busy_mid", int'(busy), 1);
    pulse_start();
    wait_for("busy_start", 0, 40, at);
    chk("busy_start_period", int'(meas_period), 8);
    idle(20);
    chk("busy_start_idle", int'(busy), 0);

    // reset during high phase
    pulse_start();
    wait_for("in_high", 2, 40, at);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_period", int'(meas_period), 0);
    chk("midrst_high", int'(meas_high), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_timeout", int'(timeout), 0);
    pulse_start();
    wait_for("after_rst", 0, 40, at);
    chk("after_rst_period", int'(meas_period), 8);
    chk("after_rst_high", int'(meas_high), 3);

    // timeout in ARM with clk_in held low
    ck_mode = 0;
    idle(20);
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 t0 = cyc;
    start = 1'b0;
    wait_for("arm_timeout", 1, 300, at);
    chk("arm_timeout_cycles", at - t0, 255);
    chk("arm_timeout_busy", int'(busy), 0);
    chk("arm_timeout_held", int'(meas_period), 8);

    // timeout in HIGH with clk_in stuck high
    pulse_start();
    ck_mode = 2;
    wait_for("stuck_rise", 2, 20, t0);
    wait_for("high_timeout", 1, 300, at);
    chk("high_timeout_cycles", at - t0, 254);
    chk("high_timeout_period", int'(meas_period), 8);
    chk("high_timeout_high", int'(meas_high), 3);
    ck_mode = 0;
    idle(20);

    // 90/30 ns clock
    ck_per  = 90;
    ck_mode = 1;
    idle(30);
    pulse_start();
    wait_for("p90", 0, 40, at);
    chk("p90_period", int'(meas_period), 9);
    chk("p90_high", int'(meas_high), 3);
`ifdef CLOCK_MONITOR_CHECK_EN
    chk("p90_period_err", int'(period_err), 1);
    chk("p90_duty_err", int'(duty_err), 0);
    ck_per = 80;
    idle(30);
    pulse_start();
    wait_for("p80", 0, 40, at);
    chk("p80_period_err", int'(period_err), 0);
    chk("p80_duty_err", int'(duty_err), 0);
`endif
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
